// File: rtl/temp_sched_pkg.sv
// Shared types and helpers for the temperature/humidity poll sequencer.
package temp_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT,
    ST_CHECK,
    ST_GAP
  } state_e;

  // Bit positions of the fields inside the 40-bit reader frame
  localparam int HUM_MSB   = 39;
  localparam int HUM_LSB   = 32;
  localparam int HUMF_MSB  = 31;
  localparam int HUMF_LSB  = 24;
  localparam int TEMP_MSB  = 23;
  localparam int TEMP_LSB  = 16;
  localparam int TEMPF_MSB = 15;
  localparam int TEMPF_LSB = 8;
  localparam int CK_MSB    = 7;
  localparam int CK_LSB    = 0;

  // Sensor checksum: modulo-256 sum of the four data bytes
  function automatic logic frame_cksum_ok(input logic [39:0] f);
    logic [7:0] sum;
    sum = f[HUM_MSB:HUM_LSB] + f[HUMF_MSB:HUMF_LSB] +
          f[TEMP_MSB:TEMP_LSB] + f[TEMPF_MSB:TEMPF_LSB];
    return (sum == f[CK_MSB:CK_LSB]);
  endfunction

endpackage

// File: rtl/temp_tick_gen.sv
// Free-running poll period counter; held at zero while disabled.
module temp_tick_gen #(
  parameter int unsigned PERIOD_CYC = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam logic [31:0] TERM = 32'(PERIOD_CYC - 1);

  logic [31:0] cnt_q, cnt_d;

  // Next count: wrap at terminal count, clear whenever disabled
  always_comb begin
    cnt_d = cnt_q;
    if (!enable)
      cnt_d = '0;
    else if (cnt_q == TERM)
      cnt_d = '0;
    else
      cnt_d = cnt_q + 32'd1;
  end

  assign tick = enable && (cnt_q == TERM);

  // Period counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/temp_poll_sched.sv
// Poll sequencer: triggers the sensor reader, supervises the transaction,
// validates the frame checksum and publishes temperature/humidity.
module temp_poll_sched
  import temp_sched_pkg::*;
#(
  parameter int unsigned PERIOD_CYC   = 100_000_000,
  parameter int unsigned MIN_GAP_CYC  = 50_000_000,
  parameter int unsigned TIMEOUT_CYC  = 2_000_000,
  parameter int unsigned TRIG_LOW_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        manual_req,
  input  logic        rd_done,
  input  logic [39:0] rd_frame,
  output logic        trigger,
  output logic [7:0]  temp_out,
  output logic [7:0]  hum_out,
  output logic        data_valid,
  output logic        upd,
  output logic        err_timeout,
  output logic        err_cksum,
  output logic [7:0]  err_cnt,
  output logic        busy
);

  localparam logic [31:0] TRIG_LAST = 32'(TRIG_LOW_CYC - 1);
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYC - 1);
  localparam logic [31:0] GAP_LAST  = 32'(MIN_GAP_CYC - 1);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        trig_q, trig_d;
  logic [7:0]  temp_q, temp_d;
  logic [7:0]  hum_q, hum_d;
  logic        valid_q, valid_d;
  logic        upd_q, upd_d;
  logic        eto_q, eto_d;
  logic        eck_q, eck_d;
  logic [7:0]  ecnt_q, ecnt_d;
  logic [39:0] frame_q;
  logic        frame_ld;
  logic        tick;
  logic        req;

  temp_tick_gen #(.PERIOD_CYC(PERIOD_CYC)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tick   (tick)
  );

  // Tick and manual request collapse into a single one-deep request
  assign req = tick | manual_req;

  // Next-state and output decode; the shared counter times TRIG, WAIT and GAP
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 32'd1;
    pend_d   = pend_q | req;
    trig_d   = 1'b1;
    temp_d   = temp_q;
    hum_d    = hum_q;
    valid_d  = valid_q;
    upd_d    = 1'b0;
    eto_d    = 1'b0;
    eck_d    = 1'b0;
    ecnt_d   = ecnt_q;
    frame_ld = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (pend_q || req) begin
          state_d = ST_TRIG;
          pend_d  = 1'b0;
          trig_d  = 1'b0;
        end
      end
      ST_TRIG: begin
        trig_d = 1'b0;
        if (cnt_q == TRIG_LAST) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
          trig_d  = 1'b1;
        end
      end
      ST_WAIT: begin
        // A frame arriving in the expiry cycle still counts as on time
        if (rd_done) begin
          state_d  = ST_CHECK;
          frame_ld = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_GAP;
          cnt_d   = '0;
          eto_d   = 1'b1;
          ecnt_d  = (ecnt_q == 8'hFF) ? ecnt_q : ecnt_q + 8'd1;
        end
      end
      ST_CHECK: begin
        state_d = ST_GAP;
        cnt_d   = '0;
        if (frame_cksum_ok(frame_q)) begin
          temp_d  = frame_q[TEMP_MSB:TEMP_LSB];
          hum_d   = frame_q[HUM_MSB:HUM_LSB];
          valid_d = 1'b1;
          upd_d   = 1'b1;
        end else begin
          eck_d  = 1'b1;
          ecnt_d = (ecnt_q == 8'hFF) ? ecnt_q : ecnt_q + 8'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Control and published-output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      trig_q  <= 1'b1;
      temp_q  <= '0;
      hum_q   <= '0;
      valid_q <= 1'b0;
      upd_q   <= 1'b0;
      eto_q   <= 1'b0;
      eck_q   <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      trig_q  <= trig_d;
      temp_q  <= temp_d;
      hum_q   <= hum_d;
      valid_q <= valid_d;
      upd_q   <= upd_d;
      eto_q   <= eto_d;
      eck_q   <= eck_d;
      ecnt_q  <= ecnt_d;
    end
  end

  // Frame capture; only read in CHECK, so it needs no reset
  always_ff @(posedge clk) begin
    if (frame_ld)
      frame_q <= rd_frame;
  end

  assign trigger     = trig_q;
  assign temp_out    = temp_q;
  assign hum_out     = hum_q;
  assign data_valid  = valid_q;
  assign upd         = upd_q;
  assign err_timeout = eto_q;
  assign err_cksum   = eck_q;
  assign err_cnt     = ecnt_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: doc/temp_poll_sched.md
# temp_poll_sched

Sequencer for the single-wire temperature/humidity sensor reader. Generates the reader's start trigger on a periodic schedule or on manual request, enforces the sensor's minimum inter-read gap, supervises each transaction with a timeout, and validates the 40-bit frame checksum before publishing temperature and humidity. Sits between the board control logic (buttons, display) and the sensor reader.

## Interface
- `PERIOD_CYC`, 100_000_000: cycles between automatic polls (2 s at 50 MHz).
- `MIN_GAP_CYC`, 50_000_000: minimum idle cycles after any transaction ends.
- `TIMEOUT_CYC`, 2_000_000: cycles allowed from trigger release to `rd_done`.
- `TRIG_LOW_CYC`, 16: trigger low-pulse width in cycles.
- `clk  in  1`: system clock; one clock domain.
- `rst  in  1`: reset; asynchronous, active-high.
- `enable  in  1`: gates the periodic poll timer only.
- `manual_req  in  1`: one-cycle poll request, accepted regardless of `enable`.
- `rd_done  in  1`: one-cycle pulse from the reader, frame complete.
- `rd_frame  in  40`: reader frame. [39:32] humidity, [31:24] humidity fraction, [23:16] temperature, [15:8] temperature fraction, [7:0] checksum.
- `trigger  out  1`: to the reader. Idle high; the reader starts on the falling edge.
- `temp_out  out  8`: last valid temperature.
- `hum_out  out  8`: last valid humidity.
- `data_valid  out  1`: sticky; set after the first good frame.
- `upd  out  1`: one-cycle pulse when `temp_out`/`hum_out` update.
- `err_timeout  out  1`: one-cycle pulse on timeout.
- `err_cksum  out  1`: one-cycle pulse on checksum mismatch.
- `err_cnt  out  8`: total errors, saturating at 255.
- `busy  out  1`: high in every state except IDLE.

## Operation
- Reset values:
  - `trigger`=1.
  - All other outputs 0.
  - State IDLE; pending flag 0; all counters 0.
- Poll timer:
  - While `enable`=1, counts 0..PERIOD_CYC-1 and emits a tick at the terminal count.
  - While `enable`=0, the counter is held at 0.
- Pending flag:
  - Set by a tick or by `manual_req`. Simultaneous sources merge into one request.
  - Cleared when IDLE accepts it.
  - Requests arriving while `busy` set the flag and are serviced after GAP. The flag is one deep; extra requests are dropped.
- States:
  - IDLE: if pending, go to TRIG and clear pending.
  - TRIG: `trigger`=0 for TRIG_LOW_CYC cycles, then `trigger`=1 and go to WAIT. `rd_done` is ignored here.
  - WAIT: timeout counter starts at 0 on entry.
    - On `rd_done`, latch `rd_frame` and go to CHECK.
    - When the counter reaches TIMEOUT_CYC, pulse `err_timeout`, increment `err_cnt`, go to GAP.
    - If `rd_done` and expiry occur in the same cycle, `rd_done` wins.
  - CHECK (1 cycle): sum = (f[39:32]+f[31:24]+f[23:16]+f[15:8]) mod 256.
    - If sum == f[7:0]: load `temp_out`=f[23:16] and `hum_out`=f[39:32], pulse `upd`, set `data_valid`.
    - Otherwise: pulse `err_cksum`, increment `err_cnt`; previous outputs are retained.
    - Go to GAP.
  - GAP: count MIN_GAP_CYC cycles, then go to IDLE.
- Deasserting `enable` mid-transaction does not abort it. The transaction completes normally.
- Async `rst` mid-transaction returns everything to reset values immediately, with `trigger`=1.

## Timing
- Pending set in cycle N while in IDLE: state is TRIG and `trigger`=0 from cycle N+1 (registered output). `trigger` returns to 1 at cycle N+1+TRIG_LOW_CYC.
- `rd_done` in cycle M: CHECK in M+1; `upd`/`temp_out` valid in M+2; GAP starts M+2.
- Every registered output changes only on a `clk` edge, except on reset.

## Structure
- Package `temp_sched_pkg`: state enum (IDLE, TRIG, WAIT, CHECK, GAP), frame field bit-position constants, and a `frame_cksum_ok` function.
- One sub-module: `temp_tick_gen`, the parameterised period counter with `enable`, emitting `tick`.

## Test plan
Bench parameters: PERIOD_CYC=100, MIN_GAP_CYC=20, TIMEOUT_CYC=50, TRIG_LOW_CYC=4.
1. `manual_req` with `enable`=0; reader model returns frame 0x3C00190055 -> `trigger` low 4 cycles; `upd` fires; `temp_out`=0x19, `hum_out`=0x3C, `data_valid`=1.
2. Reader returns frame 0x3C00190054 -> `err_cksum` pulse; `err_cnt`=1; `temp_out`/`hum_out` unchanged.
3. No `rd_done` -> `err_timeout` exactly 50 cycles after `trigger` rises; `busy` low 20 cycles later.
4. `enable`=1 with a responsive reader -> triggers every 100 cycles. `manual_req` during GAP -> exactly one extra trigger, issued when GAP ends.
5. `rst` during WAIT -> `trigger`=1 and all outputs 0 immediately; a later `rd_done` is ignored.
6. 256 forced timeouts -> `err_cnt` saturates at 255.
